uart_mmio_if: RTL and testbench



---
 rtl/uart_mmio_pkg.sv | 19 +
 rtl/uart_rx_fifo.sv | 53 +++++
 rtl/uart_mmio_if.sv | 153 +++++++++++++++
 tb/tb_uart_mmio_if.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// Register offsets, STATUS bit positions and an address-decode helper for uart_mmio_if.
package uart_mmio_pkg;

  localparam logic [3:0] UART_STATUS_OFF = 4'h0;
  localparam logic [3:0] UART_RX_OFF     = 4'h4;
  localparam logic [3:0] UART_TX_OFF     = 4'h8;

  localparam int TX_FREE_BIT  = 0;
  localparam int RX_AVAIL_BIT = 1;
  localparam int RX_OVF_BIT   = 2;
  localparam int RX_IE_BIT    = 4;
  localparam int TX_IE_BIT    = 5;

  // Word-aligned register offset; the byte-lane bits never take part in decode.
  function automatic logic [3:0] reg_off(input logic [3:0] addr);
    return {addr[3:2], 2'b00};
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO buffering received UART bytes.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  output logic       full,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty
);

  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [7:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A pop frees the slot in the same cycle, so a push into a full FIFO is taken then.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_if.sv
// CPU memory-mapped front-end for uart_core: TX holding register, RX FIFO, STATUS.
// Define UART_MMIO_IRQ_EN to add the irq output and the rx_ie/tx_ie enables.
//
// TX holding register states:
//   state   | meaning
//   TX_IDLE | no byte held, tx_valid=0, TX_DATA writes accepted
//   TX_FULL | byte held on tx_data, tx_valid=1, waits for tx_ready
module uart_mmio_if
  import uart_mmio_pkg::*;
#(
  parameter int RX_FIFO_DEPTH = 8,
  parameter int RX_PTR_W      = $clog2(RX_FIFO_DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_en,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
`ifdef UART_MMIO_IRQ_EN
  output logic        irq,
`endif
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam logic [0:0] TX_IDLE = 1'b0;
  localparam logic [0:0] TX_FULL = 1'b1;

  logic [0:0]  tx_state;
  logic        rd_req;
  logic        wr_req;
  logic        rd_rx;
  logic        wr_tx;
  logic        wr_status;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        ovf_evt;
  logic        rx_ovf;
  logic        rx_ie;
  logic        tx_ie;
  logic [31:0] status_val;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign rd_req    = bus_en & ~bus_we;
  assign wr_req    = bus_en & bus_we;
  assign rd_rx     = rd_req & (reg_off(bus_addr) == UART_RX_OFF);
  assign wr_tx     = wr_req & (reg_off(bus_addr) == UART_TX_OFF);
  assign wr_status = wr_req & (reg_off(bus_addr) == UART_STATUS_OFF);

  assign rx_ready    = rst_n;
  assign tx_valid    = (tx_state == TX_FULL);
  assign unused_bits = &{1'b0, bus_wdata[31:8], bus_addr[1:0]};

  uart_rx_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .PTR_W (RX_PTR_W)
  ) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_valid),
    .din   (rx_data),
    .full  (fifo_full),
    .pop   (rd_rx),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  // A full FIFO with a same-cycle pop still accepts the byte, so that is not an overflow.
  assign ovf_evt = rx_valid & fifo_full & ~rd_rx;

  always_comb begin
    status_val               = '0;
    status_val[TX_FREE_BIT]  = ~tx_valid;
    status_val[RX_AVAIL_BIT] = ~fifo_empty;
    status_val[RX_OVF_BIT]   = rx_ovf;
    status_val[RX_IE_BIT]    = rx_ie;
    status_val[TX_IE_BIT]    = tx_ie;
  end

  always_comb begin
    rd_val = '0;
    case (reg_off(bus_addr))
      UART_STATUS_OFF: rd_val = status_val;
      UART_RX_OFF:     rd_val = fifo_empty ? 32'h0 : {24'h0, fifo_dout};
      default:         rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_rdata <= '0;
    end else if (rd_req) begin
      bus_rdata <= rd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_data  <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (wr_tx) begin
            tx_data  <= bus_wdata[7:0];
            tx_state <= TX_FULL;
          end
        end
        default: begin
          if (tx_ready) tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_ovf <= 1'b0;
    end else if (ovf_evt) begin
      rx_ovf <= 1'b1;
    end else if (wr_status & bus_wdata[RX_OVF_BIT]) begin
      rx_ovf <= 1'b0;
    end
  end

`ifdef UART_MMIO_IRQ_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_ie <= 1'b0;
      tx_ie <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (wr_status) begin
        rx_ie <= bus_wdata[RX_IE_BIT];
        tx_ie <= bus_wdata[TX_IE_BIT];
      end
      irq <= (rx_ie & ~fifo_empty) | (tx_ie & ~tx_valid) | rx_ovf;
    end
  end
`else
  assign rx_ie = 1'b0;
  assign tx_ie = 1'b0;
`endif

endmodule

// File: tb/tb_uart_mmio_if.sv
// Directed self-checking bench for uart_mmio_if (default build, no irq).
module tb_uart_mmio_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_en;
  logic        bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  uart_mmio_if dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_en    (bus_en),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_en = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_en = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_en = 1'b1; bus_we = 1'b0; bus_addr = a;
    @(negedge clk);
    bus_en = 1'b0;
    d = bus_rdata;
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; bus_en = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_rdata", bus_rdata, 32'h0);
    chk("rst_rx_ready", 32'(rx_ready), 32'h1);
    bus_read(4'h0, rd); chk("rst_status", rd, 32'h1);

    // TX: held byte, dropped write while full, handshake
    bus_write(4'h8, 32'hA5);
    chk("tx_valid_set", 32'(tx_valid), 32'h1);
    chk("tx_data_a5", 32'(tx_data), 32'hA5);
    repeat (5) @(negedge clk);
    bus_write(4'h8, 32'h3C);
    chk("tx_drop_data", 32'(tx_data), 32'hA5);
    chk("tx_drop_valid", 32'(tx_valid), 32'h1);
    bus_read(4'h0, rd); chk("status_tx_busy", rd, 32'h0);
    @(negedge clk); tx_ready = 1'b1;
    @(negedge clk); tx_ready = 1'b0;
    chk("tx_hs_valid", 32'(tx_valid), 32'h0);
    chk("tx_hs_data", 32'(tx_data), 32'hA5);
    bus_read(4'h0, rd); chk("status_tx_free", rd, 32'h1);

    // Write coinciding with handshake completion is not chained
    bus_write(4'h8, 32'h55);
    @(negedge clk);
    tx_ready = 1'b1; bus_en = 1'b1; bus_we = 1'b1; bus_addr = 4'h8; bus_wdata = 32'h66;
    @(negedge clk);
    tx_ready = 1'b0; bus_en = 1'b0; bus_we = 1'b0;
    chk("tx_chain_valid", 32'(tx_valid), 32'h0);
    chk("tx_chain_data", 32'(tx_data), 32'h55);

    // RX basic ordering and empty read
    rx_push(8'h11); rx_push(8'h22); rx_push(8'h33);
    bus_read(4'h0, rd); chk("status_rx_avail", rd, 32'h3);
    bus_read(4'h4, rd); chk("rx_0", rd, 32'h11);
    bus_read(4'h4, rd); chk("rx_1", rd, 32'h22);
    bus_read(4'h4, rd); chk("rx_2", rd, 32'h33);
    bus_read(4'h4, rd); chk("rx_empty", rd, 32'h0);
    bus_read(4'h0, rd); chk("status_rx_drained", rd, 32'h1);
    bus_read(4'hC, rd); chk("reserved_rd", rd, 32'h0);

    // Overflow: ninth byte dropped, then W1C clear
    for (int i = 1; i <= 9; i++) rx_push(8'(i));
    bus_read(4'h0, rd); chk("status_ovf", rd, 32'h7);
    bus_write(4'h0, 32'h4);
    bus_read(4'h0, rd); chk("status_ovf_clr", rd, 32'h3);

    // Full FIFO: simultaneous push and pop
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h77; bus_en = 1'b1; bus_we = 1'b0; bus_addr = 4'h4;
    @(negedge clk);
    rx_valid = 1'b0; bus_en = 1'b0;
    chk("full_pushpop_rd", bus_rdata, 32'h01);
    bus_read(4'h0, rd); chk("full_pushpop_status", rd, 32'h3);

    // Overflow set beats a same-cycle clear
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h88; bus_en = 1'b1; bus_we = 1'b1; bus_addr = 4'h0; bus_wdata = 32'h4;
    @(negedge clk);
    rx_valid = 1'b0; bus_en = 1'b0; bus_we = 1'b0;
    bus_read(4'h0, rd); chk("ovf_set_wins", rd, 32'h7);
    bus_write(4'h0, 32'h4);

    // Drain: count stayed at 8, 0x77 stored last, 0x88 dropped
    for (int i = 2; i <= 8; i++) begin
      bus_read(4'h4, rd); chk($sformatf("drain_%0d", i), rd, 32'(i));
    end
    bus_read(4'h4, rd); chk("drain_77", rd, 32'h77);
    bus_read(4'h0, rd); chk("status_after_drain", rd, 32'h1);

    // Empty FIFO: simultaneous push and read returns 0, push kept
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h99; bus_en = 1'b1; bus_we = 1'b0; bus_addr = 4'h4;
    @(negedge clk);
    rx_valid = 1'b0; bus_en = 1'b0;
    chk("empty_pushpop_rd", bus_rdata, 32'h0);
    bus_read(4'h4, rd); chk("empty_pushpop_kept", rd, 32'h99);

    // Reset mid-transfer
    rx_push(8'hA1); rx_push(8'hA2); rx_push(8'hA3); rx_push(8'hA4);
    bus_write(4'h8, 32'hC3);
    chk("pre_rst_tx_valid", 32'(tx_valid), 32'h1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'h0);
    chk("mid_rst_rdata", bus_rdata, 32'h0);
    chk("mid_rst_rx_ready", 32'(rx_ready), 32'h1);
    bus_read(4'h0, rd); chk("mid_rst_status", rd, 32'h1);
    bus_read(4'h4, rd); chk("mid_rst_rx_empty", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
